adder_err_accum: RTL and testbench
==================================

// Module: adder_err_accum
// PURPOSE
//  Downstream error-evaluation stage for the 6-bit ripple adder under test (12 inputs, 7-bit sum).
//  Accepts a stream of (a, b, approx_sum) samples via valid/ready, computes the exact a+b internally,
//  and accumulates |approx-exact| statistics over a programmed sample count.
//  Reports the error count, summed absolute error, max absolute error and the index of the first max.
// PARAMETERS
//  W      6   operand width; sum and error width is W+1
//  CNT_W  13  width of n_samples, sample index and err_count
//  ACC_W  20  width of sum_abs_err accumulator
// PORTS
//  clk          in   1      rising-edge clock
//  rst          in   1      synchronous, active-high reset
//  start        in   1      begin a run; sampled only in IDLE
//  n_samples    in   CNT_W  samples in the run, latched on start
//  in_valid     in   1      sample valid
//  in_ready     out  1      block can accept a sample
//  in_a         in   W      operand a (adder inputs pi00..pi05, LSB first)
//  in_b         in   W      operand b (adder inputs pi06..pi11, LSB first)
//  in_approx    in   W+1    sum under test (po0..po6, LSB first)
//  busy         out  1      run in progress (RUN or DRAIN)
//  done         out  1      one-cycle pulse; results final in that cycle
//  err_count    out  CNT_W  samples with nonzero error
//  sum_abs_err  out  ACC_W  sum of |error|, saturating
//  max_abs_err  out  W+1    largest |error| seen
//  max_idx      out  CNT_W  0-based index of the first sample reaching max_abs_err
// BEHAVIOUR
//  - Reset: state=IDLE. in_ready, busy and done are 0. All result outputs and internal registers are 0.
//  - FSM states: IDLE, RUN, DRAIN, FIN.
//    IDLE : start=1 clears results, idx and the stage-1 register, and latches n_samples.
//           Next state is RUN, or FIN when n_samples==0.
//    RUN  : in_ready=1 and busy=1. A handshake (in_valid & in_ready) at an edge accepts one sample and idx++.
//           The handshake that accepts sample n_samples-1 moves the FSM to DRAIN.
//    DRAIN: in_ready=0 and busy=1. The final accumulation happens at this edge. Next state is FIN.
//    FIN  : done=1 for exactly one cycle, busy=0. Next state is IDLE.
//  - start outside IDLE is ignored. Results hold from FIN until the next accepted start.
//  - Pipeline, stage 1 (handshake edge): err = |in_approx - (in_a+in_b)|.
//    The difference is computed at W+2-bit signed width. err fits W+1 bits (max 2^(W+1)-1).
//    The edge registers err and its idx, and sets s1_valid.
//  - Pipeline, stage 2 (next edge, when s1_valid):
//    - err_count increments when err!=0.
//    - sum_abs_err adds err and saturates at 2^ACC_W-1.
//    - When err > max_abs_err (strictly greater), the edge updates max_abs_err and max_idx, so ties keep
//      the first index. With all errors 0, max_idx stays 0.
//  - Back-to-back handshakes sustain 1 sample/cycle. in_valid gaps are allowed, and s1_valid drops in gap cycles.
//  - Latency: when the last handshake is at edge t, results are final and done=1 during the cycle after edge t+1.
//  - The inputs in_a, in_b and in_approx are sampled only at handshake edges. Their values are don't-care otherwise.
//  - rst mid-run: at that edge everything returns to reset values. No done pulse. Partial results are discarded.
// TESTING
//  1. Exact sums, all 4096 (a,b) pairs, n=4096 -> err_count=0, sum_abs_err=0, max_abs_err=0, max_idx=0,
//     one done pulse.
//  2. n=1, a=63, b=63, approx=0 -> err_count=1, sum=126, max=126, max_idx=0, done 2 cycles after handshake.
//  3. n=4, errors {3,5,5,0} (e.g. a=1,b=1,approx={5,7,7,2}) -> count=3, sum=13, max=5, max_idx=1 (tie keeps first).
//  4. n=3, in_valid toggling 1,0,0,1,0,1 -> handshakes exactly at valid cycles, in_ready=0 from DRAIN,
//     results match gap-free run.
//  5. start with n=0 -> done the cycle after FIN entry, all results 0. start pulsed during RUN -> ignored, run count unchanged.
//  6. rst asserted mid-run after 2 of 5 samples -> next cycle all outputs 0, state IDLE, no done pulse.
//     A new start with n=1 runs cleanly.

Source files
------------

// File: rtl/adder_err_accum.sv
// Error-evaluation stage for the 6-bit ripple adder under test: accumulates
// |approx - (a+b)| statistics over a programmed number of streamed samples.
module adder_err_accum #(
   parameter int W     = 6,
   parameter int CNT_W = 13,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] n_samples,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_a,
   input  logic [W-1:0]     in_b,
   input  logic [W:0]       in_approx,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] err_count,
   output logic [ACC_W-1:0] sum_abs_err,
   output logic [W:0]       max_abs_err,
   output logic [CNT_W-1:0] max_idx
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_FIN} state_t;

   state_t           state, state_nx;
   logic [CNT_W-1:0] n_lat, idx, s1_idx;
   logic [W:0]       s1_err;
   logic             s1_valid;
   logic             hs;
   logic [W+1:0]     exact, diff;
   logic [W:0]       err;
   logic [ACC_W:0]   sum_ext;

   assign hs = in_valid & in_ready;

   // Difference at W+2 bits; the sign bit selects which operand order gives |error|.
   always_comb begin
      exact = {2'b00, in_a} + {2'b00, in_b};
      diff  = {1'b0, in_approx} - exact;
      err   = diff[W+1] ? (W+1)'(exact - {1'b0, in_approx}) : (W+1)'(diff);
   end

   assign sum_ext = {1'b0, sum_abs_err} + (ACC_W+1)'(s1_err);

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      busy     = 1'b0;
      done     = 1'b0;
      case (state)
         S_IDLE: begin
            if (start) state_nx = (n_samples == '0) ? S_FIN : S_RUN;
         end
         S_RUN: begin
            in_ready = 1'b1;
            busy     = 1'b1;
            if (in_valid && idx == n_lat - CNT_W'(1)) state_nx = S_DRAIN;
         end
         S_DRAIN: begin
            busy     = 1'b1;
            state_nx = S_FIN;
         end
         S_FIN: begin
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         n_lat       <= '0;
         idx         <= '0;
         s1_idx      <= '0;
         s1_err      <= '0;
         s1_valid    <= 1'b0;
         err_count   <= '0;
         sum_abs_err <= '0;
         max_abs_err <= '0;
         max_idx     <= '0;
      end else if (state == S_IDLE && start) begin
         n_lat       <= n_samples;
         idx         <= '0;
         s1_idx      <= '0;
         s1_err      <= '0;
         s1_valid    <= 1'b0;
         err_count   <= '0;
         sum_abs_err <= '0;
         max_abs_err <= '0;
         max_idx     <= '0;
      end else begin
         s1_valid <= hs;
         if (hs) begin
            s1_err <= err;
            s1_idx <= idx;
            idx    <= idx + CNT_W'(1);
         end
         if (s1_valid) begin
            if (s1_err != '0) err_count <= err_count + CNT_W'(1);
            sum_abs_err <= sum_ext[ACC_W] ? '1 : sum_ext[ACC_W-1:0];
            // Strictly greater so that ties keep the earliest index.
            if (s1_err > max_abs_err) begin
               max_abs_err <= s1_err;
               max_idx     <= s1_idx;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_err_accum.sv
// Bench for adder_err_accum: table vectors, directed multi-cycle sequences and
// randomized runs checked against a plain-arithmetic reference model.
module tb_adder_err_accum;
   localparam int W = 6, CNT_W = 13, ACC_W = 20;

   logic             clk = 1'b0;
   logic             rst, start, in_valid;
   logic [CNT_W-1:0] n_samples;
   logic [W-1:0]     in_a, in_b;
   logic [W:0]       in_approx;
   logic             in_ready, busy, done;
   logic [CNT_W-1:0] err_count, max_idx;
   logic [ACC_W-1:0] sum_abs_err;
   logic [W:0]       max_abs_err;

   int checks = 0, failures = 0;
   int qa[$], qb[$], qx[$];
   bit pat[$];

   typedef struct {
      int a, b, x;
      int cnt, sum, mx;
   } vec_t;
   vec_t tbl[6];

   adder_err_accum #(.W(W), .CNT_W(CNT_W), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .in_approx(in_approx), .busy(busy), .done(done), .err_count(err_count),
      .sum_abs_err(sum_abs_err), .max_abs_err(max_abs_err), .max_idx(max_idx)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic model(output longint cnt, output longint sum, output longint mx, output longint mi);
      longint e;
      cnt = 0; sum = 0; mx = 0; mi = 0;
      foreach (qa[i]) begin
         e = qx[i] - (qa[i] + qb[i]);
         if (e < 0) e = -e;
         if (e != 0) cnt++;
         sum += e;
         if (sum > (longint'(1) << ACC_W) - 1) sum = (longint'(1) << ACC_W) - 1;
         if (e > mx) begin
            mx = e;
            mi = i;
         end
      end
   endtask

   task automatic clear_q();
      qa.delete(); qb.delete(); qx.delete(); pat.delete();
   endtask

   task automatic push(input int a, input int b, input int x);
      qa.push_back(a); qb.push_back(b); qx.push_back(x);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_count"}, err_count, 0);
      chk({nm, "_sum"}, sum_abs_err, 0);
      chk({nm, "_max"}, max_abs_err, 0);
      chk({nm, "_idx"}, max_idx, 0);
   endtask

   // Runs one start..done transaction over the queued samples.
   task automatic run(input string nm, input int gap_pct, input bit poke);
      int n, got, cyc;
      bit hs;
      longint ec, es, em, ei;
      n = qa.size();
      got = 0; cyc = 0;
      model(ec, es, em, ei);
      @(negedge clk);
      start = 1'b1;
      n_samples = CNT_W'(n);
      @(negedge clk);
      start = 1'b0;
      if (n != 0) begin
         while (got < n && cyc < 20000) begin
            start = poke && (got == 1);
            if (start) n_samples = CNT_W'(7);
            if (pat.size() > 0) in_valid = pat[cyc % pat.size()];
            else in_valid = ($urandom_range(99) >= gap_pct);
            in_a = W'(qa[got]);
            in_b = W'(qb[got]);
            in_approx = (W+1)'(qx[got]);
            chk({nm, "_ready_run"}, in_ready, 1);
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) got++;
            @(negedge clk);
            cyc++;
         end
         start = 1'b0;
         in_valid = 1'b0;
         in_a = W'($urandom);
         in_approx = (W+1)'($urandom);
         if (got < n) chk({nm, "_timeout"}, got, n);
         chk({nm, "_ready_drain"}, in_ready, 0);
         chk({nm, "_busy_drain"}, busy, 1);
         chk({nm, "_done_early"}, done, 0);
         @(negedge clk);
      end
      chk({nm, "_done"}, done, 1);
      chk({nm, "_busy_fin"}, busy, 0);
      chk({nm, "_count"}, err_count, ec);
      chk({nm, "_sum"}, sum_abs_err, es);
      chk({nm, "_max"}, max_abs_err, em);
      chk({nm, "_idx"}, max_idx, ei);
      @(negedge clk);
      chk({nm, "_done_pulse"}, done, 0);
      chk({nm, "_busy_idle"}, busy, 0);
      chk({nm, "_hold_count"}, err_count, ec);
   endtask

   initial begin
      int n;
      longint base;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; n_samples = '0;
      in_a = '0; in_b = '0; in_approx = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_ready", in_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk_zero("rst");
      rst = 1'b0;

      tbl[0] = '{a: 63, b: 63, x: 0,   cnt: 1, sum: 126, mx: 126};
      tbl[1] = '{a: 0,  b: 0,  x: 127, cnt: 1, sum: 127, mx: 127};
      tbl[2] = '{a: 5,  b: 3,  x: 8,   cnt: 0, sum: 0,   mx: 0};
      tbl[3] = '{a: 10, b: 20, x: 29,  cnt: 1, sum: 1,   mx: 1};
      tbl[4] = '{a: 10, b: 20, x: 31,  cnt: 1, sum: 1,   mx: 1};
      tbl[5] = '{a: 40, b: 33, x: 64,  cnt: 1, sum: 9,   mx: 9};
      for (int i = 0; i < 6; i++) begin
         clear_q();
         push(tbl[i].a, tbl[i].b, tbl[i].x);
         run($sformatf("vec%0d", i), 0, 1'b0);
         chk($sformatf("vec%0d_tbl_count", i), err_count, tbl[i].cnt);
         chk($sformatf("vec%0d_tbl_sum", i), sum_abs_err, tbl[i].sum);
         chk($sformatf("vec%0d_tbl_max", i), max_abs_err, tbl[i].mx);
      end

      // All exact sums
      clear_q();
      for (int a = 0; a < 64; a++)
         for (int b = 0; b < 64; b++) push(a, b, a + b);
      run("exact", 0, 1'b0);
      chk_zero("exact_const");

      // Tie keeps first index
      clear_q();
      push(1, 1, 5); push(1, 1, 7); push(1, 1, 7); push(1, 1, 2);
      run("tie", 0, 1'b0);
      chk("tie_count", err_count, 3);
      chk("tie_sum", sum_abs_err, 13);
      chk("tie_max", max_abs_err, 5);
      chk("tie_idx", max_idx, 1);

      // Gapped valid pattern
      clear_q();
      push(7, 9, 20); push(63, 0, 60); push(30, 30, 70);
      pat.push_back(1); pat.push_back(0); pat.push_back(0);
      pat.push_back(1); pat.push_back(0); pat.push_back(1);
      run("gap", 0, 1'b0);
      chk("gap_count", err_count, 3);
      chk("gap_sum", sum_abs_err, 17);
      chk("gap_max", max_abs_err, 10);
      chk("gap_idx", max_idx, 2);

      // n=0 after a nonzero run, then start poked during RUN
      clear_q();
      run("n0", 0, 1'b0);
      chk_zero("n0_const");
      clear_q();
      for (int i = 0; i < 5; i++) push(i, 2 * i, 3 * i + i);
      run("poke", 20, 1'b1);

      // Reset mid-run after 2 of 5 samples
      clear_q();
      @(negedge clk);
      start = 1'b1; n_samples = CNT_W'(5);
      @(negedge clk);
      start = 1'b0;
      in_valid = 1'b1; in_a = 6'd63; in_b = 6'd63; in_approx = '0;
      repeat (2) @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mrst_ready", in_ready, 0);
      chk("mrst_busy", busy, 0);
      chk("mrst_done", done, 0);
      chk_zero("mrst");
      n = 0;
      repeat (6) begin
         @(negedge clk);
         if (done || busy) n++;
      end
      chk("mrst_no_done", n, 0);
      push(2, 3, 9);
      run("after_rst", 0, 1'b0);

      // Randomized runs
      for (int r = 0; r < 10; r++) begin
         clear_q();
         n = $urandom_range(60, 1);
         for (int i = 0; i < n; i++) begin
            int a, b, x;
            a = $urandom_range(63);
            b = $urandom_range(63);
            case ($urandom_range(2))
               0: x = a + b;
               1: begin
                  base = a + b + $signed($urandom_range(8)) - 4;
                  x = (base < 0) ? 0 : (base > 127) ? 127 : int'(base);
               end
               default: x = $urandom_range(127);
            endcase
            push(a, b, x);
         end
         run($sformatf("rand%0d", r), 30, 1'b0);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
